sequencer_lut_loader: RTL

- Host-side programmer for the sequencer FSM's LUT write/read port.
- Host writes packed 29-bit LUT entries (sof[28], eof[27], data_length[26:11], repeat_count[10:3], next_state[2:0]) into a local shadow buffer.
- On commit, the block holds the sequencer in reset, bursts the entries into the sequencer LUT, and optionally reads them back and compares them.
- Releases the sequencer only after a clean load.

---
 rtl/sequencer_lut_loader_if.sv | 27 ++
 rtl/sequencer_lut_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer_lut_loader_if.sv
// Sequencer LUT programming port: sequencer reset, write burst and readback.
// The loader side is the master; the sequencer (or its model) is the slave.
interface sequencer_lut_loader_if #(
    parameter int ENTRY_W = 29
);
    logic               seq_reset_o;
    logic               lut_wen_o;
    logic [ENTRY_W-1:0] lut_wdata_o;
    logic               lut_rden_o;
    logic [ENTRY_W-1:0] lut_read_data_i;

    modport master (
        output seq_reset_o,
        output lut_wen_o,
        output lut_wdata_o,
        output lut_rden_o,
        input  lut_read_data_i
    );

    modport slave (
        input  seq_reset_o,
        input  lut_wen_o,
        input  lut_wdata_o,
        input  lut_rden_o,
        output lut_read_data_i
    );
endinterface

// File: rtl/sequencer_lut_loader.sv
// Host-side programmer for the sequencer LUT. The host fills a shadow buffer,
// then a commit holds the sequencer in reset, bursts the entries into its LUT,
// optionally reads them back for comparison, and releases the sequencer only
// when the load was clean.
module sequencer_lut_loader #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int ENTRY_W    = 29,
    parameter int SETTLE_CYC = 4,
    parameter int GAP_CYC    = 2,
    parameter int READ_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n_i,
    input  logic                   host_wr_i,
    input  logic [ADDR_W-1:0]      host_addr_i,
    input  logic [ENTRY_W-1:0]     host_wdata_i,
    input  logic [ADDR_W:0]        host_count_i,
    input  logic                   host_verify_i,
    input  logic                   host_commit_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cfg_err_o,
    output logic                   verify_err_o,
    output logic [ADDR_W-1:0]      err_index_o,
    sequencer_lut_loader_if.master lut
);

    localparam int HC_W  = ADDR_W + 1;
    localparam int CNT_W = $clog2(DEPTH + SETTLE_CYC + GAP_CYC + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, WRITE, GAP, READ, CHECK, DONE
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [CNT_W-1:0]   n_last;
    logic               verify_en;
    logic [CNT_W-1:0]   ret_idx;
    logic [READ_LAT-1:0] rd_pipe;
    logic [ENTRY_W-1:0] shadow [DEPTH];

    logic               count_ok, commit_ok, commit_bad;
    logic               ret_valid, ret_last;

    logic               busy_q, done_q, cfg_err_q, verify_err_q, seq_reset_q;
    logic               wen_q, rden_q;
    logic [ENTRY_W-1:0] wdata_q;
    logic [ADDR_W-1:0]  err_index_q;

    logic               busy_next, done_next, cfg_err_next, verify_err_next, seq_reset_next;
    logic               wen_next, rden_next;
    logic [ENTRY_W-1:0] wdata_next;
    logic [ADDR_W-1:0]  err_index_next;

    // Wide counters (CNT_W > ADDR_W) keep index DEPTH-1 distinct from wrap-around.
    assign count_ok  = (host_count_i != '0) && (host_count_i <= HC_W'(DEPTH));
    assign ret_valid = rd_pipe[READ_LAT-1];
    assign ret_last  = ret_valid && (ret_idx == n_last);

    // Shadow buffer is host-writable only while idle and is deliberately never reset.
    always_ff @(posedge clk) begin
        if (host_wr_i && (state == IDLE)) begin
            shadow[host_addr_i] <= host_wdata_i;
        end
    end

    // Next-state sequencing and next values of every registered output.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        commit_ok       = 1'b0;
        commit_bad      = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_commit_i) begin
                    if (count_ok) begin
                        commit_ok  = 1'b1;
                        state_next = SETTLE;
                        cnt_next   = '0;
                    end else begin
                        commit_bad = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_next = WRITE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            WRITE: begin
                if (cnt == n_last) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    state_next = verify_en ? READ : DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            READ: begin
                if (cnt == n_last) begin
                    state_next = CHECK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            CHECK: begin
                if (ret_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cfg_err_next = cfg_err_q;
        if (commit_ok) begin
            cfg_err_next = 1'b0;
        end else if (commit_bad) begin
            cfg_err_next = 1'b1;
        end

        verify_err_next = verify_err_q;
        err_index_next  = err_index_q;
        if (commit_ok) begin
            verify_err_next = 1'b0;
            err_index_next  = '0;
        end else if (ret_valid && !verify_err_q &&
                     (lut.lut_read_data_i != shadow[ret_idx[ADDR_W-1:0]])) begin
            verify_err_next = 1'b1;
            err_index_next  = ret_idx[ADDR_W-1:0];
        end

        seq_reset_next = seq_reset_q;
        if (commit_ok) begin
            seq_reset_next = 1'b1;
        end else if ((state == DONE) && !cfg_err_q) begin
            seq_reset_next = verify_err_q;
        end

        busy_next  = (state_next != IDLE) && !((state_next == DONE) && cfg_err_next);
        done_next  = (state_next == DONE);
        wen_next   = (state_next == WRITE);
        wdata_next = wen_next ? shadow[cnt_next[ADDR_W-1:0]] : '0;
        rden_next  = (state_next == READ);
    end

    // State, counters, load parameters and all outputs are registered here.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            cnt          <= '0;
            n_last       <= '0;
            verify_en    <= 1'b0;
            ret_idx      <= '0;
            rd_pipe      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            verify_err_q <= 1'b0;
            err_index_q  <= '0;
            seq_reset_q  <= 1'b1;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            rden_q       <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            if (commit_ok) begin
                n_last    <= CNT_W'(host_count_i) - CNT_ONE;
                verify_en <= host_verify_i;
                ret_idx   <= '0;
            end else if (ret_valid) begin
                ret_idx <= ret_idx + CNT_ONE;
            end
            rd_pipe[0] <= rden_q;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            busy_q       <= busy_next;
            done_q       <= done_next;
            cfg_err_q    <= cfg_err_next;
            verify_err_q <= verify_err_next;
            err_index_q  <= err_index_next;
            seq_reset_q  <= seq_reset_next;
            wen_q        <= wen_next;
            wdata_q      <= wdata_next;
            rden_q       <= rden_next;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign cfg_err_o       = cfg_err_q;
    assign verify_err_o    = verify_err_q;
    assign err_index_o     = err_index_q;
    assign lut.seq_reset_o = seq_reset_q;
    assign lut.lut_wen_o   = wen_q;
    assign lut.lut_wdata_o = wdata_q;
    assign lut.lut_rden_o  = rden_q;

endmodule
